// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: shared address map, widths and the access decoder.
package mem_io_responder_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] IO_BASE = 32'h0003_0000;
  localparam logic [ADDR_W-1:0] HALT_OFF = 32'h0000_0004;
  localparam int IO_SEL_HI = 17;
  localparam int IO_SEL_LO = 16;
  localparam logic [1:0] IO_SEL = 2'b11;
  typedef enum logic [2:0] {OP_RAM_RD, OP_RAM_WR, OP_TX, OP_RX, OP_HALT, OP_IO_NOP} io_op_e;
  function automatic io_op_e decode_op(input logic [ADDR_W-1:0] a, input logic wr);
    return a[IO_SEL_HI:IO_SEL_LO] != IO_SEL ? (wr ? OP_RAM_WR : OP_RAM_RD) :
           a == IO_BASE ? (wr ? OP_TX : OP_RX) :
           (wr && a == IO_BASE + HALT_OFF) ? OP_HALT : OP_IO_NOP;
  endfunction
endpackage

// File: rtl/mem_io_responder_io_byte_fifo.sv
// io_byte_fifo: byte FIFO that drops pushes when full and ignores pops when empty.
module io_byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W = DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus TX/halt IO window; RX path built only with MEM_IO_RX_FIFO_EN.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] mem_a,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_wr,
  output logic [DATA_W-1:0] mem_din,
  output logic              io_buffer_full,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              sim_halt,
  output logic              tx_overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [DATA_W-1:0] ram [1 << RAM_ADDR_BITS];
  io_op_e op;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0] tx_cnt, tx_nxt;
  logic [DATA_W-1:0] rx_byte, rd_byte;
  assign op = decode_op(mem_a, mem_wr);
  assign tx_push = rdy && op == OP_TX;
  assign tx_pop = tx_valid && tx_ready;
  assign tx_valid = !tx_empty;
  assign tx_nxt = tx_cnt + CW'(tx_push && !tx_full) - CW'(tx_pop);
  io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(mem_dout),
    .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );
`ifdef MEM_IO_RX_FIFO_EN
  logic rx_empty, rx_full_unused;
  logic [DATA_W-1:0] rx_dout;
  logic [CW-1:0] rx_cnt_unused;
  io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rdy && rx_valid), .pop(rdy && op == OP_RX), .din(rx_data),
    .dout(rx_dout), .full(rx_full_unused), .empty(rx_empty), .count(rx_cnt_unused)
  );
  assign rx_byte = rx_empty ? '0 : rx_dout;
`else
  logic rx_unused;
  assign rx_unused = ^{rx_data, rx_valid};
  assign rx_byte = '0;
`endif
  always_comb
    rd_byte = op == OP_RAM_RD ? ram[mem_a[RAM_ADDR_BITS-1:0]] : op == OP_RX ? rx_byte : '0;
  // RAM has no reset so its contents survive rst
  always_ff @(posedge clk)
    if (rst && rdy && op == OP_RAM_WR) ram[mem_a[RAM_ADDR_BITS-1:0]] <= mem_dout;
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_din <= '0;
      io_buffer_full <= 1'b0;
      sim_halt <= 1'b0;
      tx_overflow <= 1'b0;
    end else if (rdy) begin
      mem_din <= rd_byte;
      io_buffer_full <= tx_nxt >= CW'(FIFO_DEPTH - 2);
      sim_halt <= sim_halt || op == OP_HALT;
      tx_overflow <= tx_overflow || (tx_push && tx_full);
    end
  end
endmodule
